// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam logic [AW-1:0] X0_ADDR = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding buffer with a valid/ready accept port.
// Writes to x0 are accepted but never loaded.
module wb_hold_slot
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_grant,
  output logic            o_ready,
  output logic            o_load,
  output wb_entry_t       o_entry
);
  wb_entry_t r_entry;
  logic      w_accept;

  // Handshake: a transfer happens on a rising edge where i_valid & o_ready.
  // A granted entry frees the slot in the same cycle, so a new one can follow back-to-back.
  assign o_ready  = !r_entry.valid | i_grant;
  assign w_accept = i_valid & o_ready;
  assign o_load   = w_accept & (i_addr != X0_ADDR);
  assign o_entry  = r_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= '0;
    end else if (o_load) begin
      r_entry.valid <= 1'b1;
      r_entry.addr  <= i_addr;
      r_entry.data  <= i_data;
    end else if (i_grant) begin
      r_entry.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two buffered writeback requesters onto one register-file write port
// and exports per-register pending status. Define WB_ARB_STATS_EN for conflict_cnt.
module regfile_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  input  logic [AW-1:0]   chk_addrA,
  input  logic [AW-1:0]   chk_addrB,
  output logic            hazA,
  output logic            hazB,
  output logic [NREG-1:0] pending
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]     conflict_cnt
`endif
);
  import rf_pkg::wb_entry_t;

  wb_entry_t w_hold_a;
  wb_entry_t w_hold_b;
  logic      w_load_a;
  logic      w_load_b;
  logic      w_grant_a;
  logic      w_grant_b;
  logic      w_surv_b;
  logic      r_age;
  logic      r_rr;

  wb_hold_slot u_hold_a (
    .clk     (clk),
    .rst     (rst),
    .i_valid (a_valid),
    .i_addr  (a_addr),
    .i_data  (a_data),
    .i_grant (w_grant_a),
    .o_ready (a_ready),
    .o_load  (w_load_a),
    .o_entry (w_hold_a)
  );

  wb_hold_slot u_hold_b (
    .clk     (clk),
    .rst     (rst),
    .i_valid (b_valid),
    .i_addr  (b_addr),
    .i_data  (b_data),
    .i_grant (w_grant_b),
    .o_ready (b_ready),
    .o_load  (w_load_b),
    .o_entry (w_hold_b)
  );

  // r_age=1 means hold B is older; grants are suppressed while reset is asserted.
  assign w_grant_a = !rst & w_hold_a.valid & (!w_hold_b.valid | !r_age);
  assign w_grant_b = !rst & w_hold_b.valid & (!w_hold_a.valid | r_age);
  assign w_surv_b  = w_hold_b.valid & !w_grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= 1'b0;
      r_rr  <= 1'b0;
    end else if (w_load_a & w_load_b) begin
      r_age <= r_rr;
      r_rr  <= !r_rr;
    end else if (w_load_a) begin
      r_age <= w_surv_b;
    end else if (w_load_b) begin
      r_age <= 1'b0;
    end
  end

  always_comb begin
    rf_wr_en   = w_grant_a | w_grant_b;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (w_grant_a) begin
      rf_wr_addr = w_hold_a.addr;
      rf_wr_data = w_hold_a.data;
    end else if (w_grant_b) begin
      rf_wr_addr = w_hold_b.addr;
      rf_wr_data = w_hold_b.data;
    end
  end

  // Register 0 is never pending since x0 writes are never buffered.
  always_comb begin
    pending = '0;
    for (int r = 1; r < NREG; r++) begin
      pending[r] = (w_hold_a.valid & (w_hold_a.addr == AW'(r))) |
                   (w_hold_b.valid & (w_hold_b.addr == AW'(r)));
    end
  end

  assign hazA = pending[chk_addrA];
  assign hazB = pending[chk_addrB];

`ifdef WB_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_hold_a.valid & w_hold_b.valid & (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset and counter sequences.
module tb_regfile_wb_arbiter;
  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk;
  logic            rst;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [AW-1:0]   a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [AW-1:0]   chk_addrA, chk_addrB;
  logic            hazA, hazB;
  logic [NREG-1:0] pending;
`ifdef WB_ARB_STATS_EN
  logic [15:0]     conflict_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [AW+XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]    rf_model [NREG];

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .chk_addrA  (chk_addrA),
    .chk_addrB  (chk_addrB),
    .hazA       (hazA),
    .hazB       (hazB),
    .pending    (pending)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            av;
    logic [AW-1:0]   aa;
    logic [XLEN-1:0] ad;
    logic            bv;
    logic [AW-1:0]   ba;
    logic [XLEN-1:0] bd;
    logic [AW-1:0]   ca;
    logic [AW-1:0]   cb;
    logic            e_wr;
    logic [AW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    logic            e_ar;
    logic            e_br;
    logic [NREG-1:0] e_pend;
    logic            e_ha;
    logic            e_hb;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(
    input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
    input logic bv, input logic [AW-1:0] ba, input logic [XLEN-1:0] bd,
    input logic [AW-1:0] ca, input logic [AW-1:0] cb,
    input logic e_wr, input logic [AW-1:0] e_addr, input logic [XLEN-1:0] e_data,
    input logic e_ar, input logic e_br, input logic [NREG-1:0] e_pend,
    input logic e_ha, input logic e_hb);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.ca = ca; v.cb = cb;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_ar = e_ar; v.e_br = e_br; v.e_pend = e_pend;
    v.e_ha = e_ha; v.e_hb = e_hb;
    return v;
  endfunction

  // Driver tasks
  task automatic set_in(
    input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
    input logic bv, input logic [AW-1:0] ba, input logic [XLEN-1:0] bd,
    input logic [AW-1:0] ca, input logic [AW-1:0] cb);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    chk_addrA = ca; chk_addrB = cb;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write seen on the port must match the next expected write.
  task automatic sample_write();
    logic [AW+XLEN-1:0] e;
    if (rf_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got write %0h <= %0h expected no write", rf_wr_addr, rf_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {rf_wr_addr, rf_wr_data}, e);
      end
      rf_model[rf_wr_addr] = rf_wr_data;
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    set_in(v.av, v.aa, v.ad, v.bv, v.ba, v.bd, v.ca, v.cb);
    #1;
    check($sformatf("v%0d_wr_en", i), rf_wr_en, v.e_wr);
    if (v.e_wr) begin
      check($sformatf("v%0d_wr_addr", i), rf_wr_addr, v.e_addr);
      check($sformatf("v%0d_wr_data", i), rf_wr_data, v.e_data);
    end
    check($sformatf("v%0d_a_ready", i), a_ready, v.e_ar);
    check($sformatf("v%0d_b_ready", i), b_ready, v.e_br);
    check($sformatf("v%0d_pending", i), pending, v.e_pend);
    check($sformatf("v%0d_hazA", i), hazA, v.e_ha);
    check($sformatf("v%0d_hazB", i), hazB, v.e_hb);
    sample_write();
  endtask

  task automatic step(
    input string name,
    input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
    input logic bv, input logic [AW-1:0] ba, input logic [XLEN-1:0] bd,
    input logic e_wr, input logic [AW-1:0] e_addr);
    @(negedge clk);
    set_in(av, aa, ad, bv, ba, bd, 5'd0, 5'd0);
    #1;
    check({name, "_wr_en"}, rf_wr_en, e_wr);
    if (e_wr) check({name, "_wr_addr"}, rf_wr_addr, e_addr);
    sample_write();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) rf_model[r] = '0;

    //             A req              B req              chk      write             rdy   pending    haz
    vecs[0]  = mk(0, 0, 0,           0, 0, 0,           5, 0,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          5, 0,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[2]  = mk(0, 0, 0,           0, 0, 0,           5, 0,  1, 5, 32'hDEADBEEF, 1, 1, 32'h20, 1, 0);
    vecs[3]  = mk(0, 0, 0,           0, 0, 0,           5, 0,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[4]  = mk(1, 3, 32'h11,      1, 4, 32'h22,      3, 4,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[5]  = mk(0, 0, 0,           0, 0, 0,           3, 4,  1, 3, 32'h11,      1, 0, 32'h18,  1, 1);
    vecs[6]  = mk(0, 0, 0,           0, 0, 0,           3, 4,  1, 4, 32'h22,      1, 1, 32'h10,  0, 1);
    vecs[7]  = mk(1, 3, 32'h33,      1, 4, 32'h44,      3, 4,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[8]  = mk(0, 0, 0,           0, 0, 0,           3, 4,  1, 4, 32'h44,      0, 1, 32'h18,  1, 1);
    vecs[9]  = mk(0, 0, 0,           0, 0, 0,           3, 4,  1, 3, 32'h33,      1, 1, 32'h08,  1, 0);
    vecs[10] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,          0, 0,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[11] = mk(0, 0, 0,           0, 0, 0,           0, 0,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[12] = mk(1, 9, 32'h55,      1, 7, 32'hAA,      7, 9,  0, 0, 0,           1, 1, 32'h0,   0, 0);
    vecs[13] = mk(1, 7, 32'hBB,      0, 0, 0,           7, 9,  1, 9, 32'h55,      1, 0, 32'h280, 1, 1);
    vecs[14] = mk(0, 0, 0,           0, 0, 0,           7, 9,  1, 7, 32'hAA,      0, 1, 32'h80,  1, 0);
    vecs[15] = mk(0, 0, 0,           0, 0, 0,           7, 9,  1, 7, 32'hBB,      1, 1, 32'h80,  1, 0);
    vecs[16] = mk(0, 0, 0,           0, 0, 0,           7, 9,  0, 0, 0,           1, 1, 32'h0,   0, 0);

    for (int i = 0; i < 17; i++)
      if (vecs[i].e_wr) exp_q.push_back({vecs[i].e_addr, vecs[i].e_data});

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) apply_vec(i);

    // Tie with rr=1: B goes first, leaving rr=0.
    exp_q.push_back({5'd11, 32'hC2});
    exp_q.push_back({5'd10, 32'hC1});
    step("tie3_load", 1, 10, 32'hC1, 1, 11, 32'hC2, 0, 0);
    step("tie3_b",    0, 0, 0,       0, 0, 0,       1, 11);
    step("tie3_a",    0, 0, 0,       0, 0, 0,       1, 10);
    step("tie3_idle", 0, 0, 0,       0, 0, 0,       0, 0);

    // Both holds loaded (rr flips to 1), then reset discards them.
    step("rst_load", 1, 5, 32'h1, 1, 6, 32'h2, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 5, 6);
    #1;
    check("rst_cycle_wr_en", rf_wr_en, 1'b0);
    sample_write();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after_wr_en", rf_wr_en, 1'b0);
    check("rst_after_pending", pending, 32'h0);
    check("rst_after_a_ready", a_ready, 1'b1);
    check("rst_after_b_ready", b_ready, 1'b1);
    check("rst_after_hazA", hazA, 1'b0);
    check("rst_after_hazB", hazB, 1'b0);
    sample_write();
    step("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // rr must be back at 0: A wins the first tie after reset.
    exp_q.push_back({5'd3, 32'h77});
    exp_q.push_back({5'd4, 32'h88});
    step("tie4_load", 1, 3, 32'h77, 1, 4, 32'h88, 0, 0);
    step("tie4_a",    0, 0, 0,      0, 0, 0,      1, 3);
    step("tie4_b",    0, 0, 0,      0, 0, 0,      1, 4);
    step("tie4_idle", 0, 0, 0,      0, 0, 0,      0, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    check("reg5_final", rf_model[5], 32'hDEADBEEF);
    check("reg6_final", rf_model[6], 32'h0);
    check("reg7_final", rf_model[7], 32'hBB);
    check("reg3_final", rf_model[3], 32'h77);
    check("reg0_final", rf_model[0], 32'h0);

`ifdef WB_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cnt_reset", conflict_cnt, 16'h0);
    set_in(1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("cnt_three", conflict_cnt, 16'd3);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("cnt_saturate", conflict_cnt, 16'hFFFF);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cnt_clear", conflict_cnt, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
